// File: rtl/btnevents.sv
// Sticky press/release/long-press event flags over a debounced button vector.
// Define BTNEVENTS_REPEAT_EN to add auto-repeat press pulses while held.
module btnevents #(
  parameter int NIN      = 21,
  parameter int LGHOLD   = 24,
  parameter int LGREPEAT = 22
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [NIN-1:0] i_btn,
  input  logic           i_clr,
  input  logic [NIN-1:0] i_clr_mask,
  output logic [NIN-1:0] o_pressed,
  output logic [NIN-1:0] o_released,
  output logic [NIN-1:0] o_held,
  output logic           o_int
);

  localparam logic COUNT = 1'b0;
  localparam logic DONE  = 1'b1;

  logic [NIN-1:0]    last_q;
  logic [NIN-1:0]    pressed_q, pressed_d;
  logic [NIN-1:0]    released_q, released_d;
  logic [NIN-1:0]    held_q, held_d;
  logic [NIN-1:0]    rise, fall, clr_m, rpt_set;
  logic [LGHOLD-1:0] timer_q, timer_d;
  logic              state_q, state_d;
  logic              chg, idle, restart, hold_ev;

  always_comb begin
    rise    = i_btn & ~last_q;
    fall    = ~i_btn & last_q;
    chg     = |(rise | fall);
    idle    = ~|i_btn;
    restart = chg | idle;
    clr_m   = i_clr ? i_clr_mask : '0;
  end

  // One timer shared by all buttons; it parks in DONE to avoid wrap.
  always_comb begin
    timer_d = timer_q;
    state_d = state_q;
    hold_ev = 1'b0;
    if (restart) begin
      timer_d = '0;
      state_d = COUNT;
    end else if (state_q == COUNT) begin
      if (&timer_q) begin
        hold_ev = 1'b1;
        state_d = DONE;
      end else begin
        timer_d = timer_q + LGHOLD'(1);
      end
    end
  end

`ifdef BTNEVENTS_REPEAT_EN
  logic [LGREPEAT-1:0] rpt_q, rpt_d;
  logic                rpt_run;

  always_comb begin
    rpt_run = (state_q == DONE) && !restart;
    rpt_d   = rpt_run ? rpt_q + LGREPEAT'(1) : '0;
    rpt_set = (rpt_run && (&rpt_q)) ? i_btn : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  logic unused_rpt_cfg;

  assign unused_rpt_cfg = (LGREPEAT > 0);
  assign rpt_set        = '0;
`endif

  // Set terms win over a simultaneous clear of the same bit.
  always_comb begin
    pressed_d  = (pressed_q & ~clr_m) | rise | rpt_set;
    released_d = (released_q & ~clr_m) | fall;
    held_d     = (held_q & ~clr_m) | (hold_ev ? i_btn : '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_q     <= '0;
      timer_q    <= '0;
      state_q    <= COUNT;
      pressed_q  <= '0;
      released_q <= '0;
      held_q     <= '0;
    end else begin
      last_q     <= i_btn;
      timer_q    <= timer_d;
      state_q    <= state_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      held_q     <= held_d;
    end
  end

  assign o_pressed  = pressed_q;
  assign o_released = released_q;
  assign o_held     = held_q;
  assign o_int      = |(pressed_q | released_q | held_q);

endmodule

// File: tb/tb_btnevents.sv
// Directed bench for btnevents with NIN=5, LGHOLD=4, LGREPEAT=3.
// Repeat expectations follow BTNEVENTS_REPEAT_EN.
module tb_btnevents;

  localparam int NIN = 5;

`ifdef BTNEVENTS_REPEAT_EN
  localparam logic [4:0] REP = 5'b00100;
`else
  localparam logic [4:0] REP = 5'b00000;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NIN-1:0] btn;
  logic           clr;
  logic [NIN-1:0] mask;
  logic [NIN-1:0] pressed, released, held;
  logic           irq;

  int nvec = 0;
  int nerr = 0;

  btnevents #(
    .NIN(5),
    .LGHOLD(4),
    .LGREPEAT(3)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_btn(btn),
    .i_clr(clr),
    .i_clr_mask(mask),
    .o_pressed(pressed),
    .o_released(released),
    .o_held(held),
    .o_int(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clr_all();
    clr  = 1'b1;
    mask = 5'h1f;
    tick(1);
    clr  = 1'b0;
    mask = '0;
  endtask

  initial begin
    rst  = 1'b1;
    btn  = '0;
    clr  = 1'b0;
    mask = '0;
    tick(3);
    chk("rst_p", pressed, 5'b0);
    chk("rst_r", released, 5'b0);
    chk("rst_h", held, 5'b0);
    chk("rst_int", {4'b0, irq}, 5'b0);
    rst = 1'b0;
    tick(1);
    chk("idle_p", pressed, 5'b0);

    // Single press, long hold
    btn = 5'b00100;
    tick(1);
    chk("s1_p", pressed, 5'b00100);
    chk("s1_int", {4'b0, irq}, 5'b1);
    chk("s1_h0", held, 5'b0);
    tick(15);
    chk("s1_hpre", held, 5'b0);
    tick(1);
    chk("s1_h", held, 5'b00100);
    chk("s1_r", released, 5'b0);
    clr_all();
    chk("clr_p", pressed, 5'b0);
    chk("clr_h", held, 5'b0);
    chk("clr_int", {4'b0, irq}, 5'b0);

    // Short press and release
    btn = '0;
    tick(1);
    chk("s2_r2", released, 5'b00100);
    clr_all();
    btn = 5'b00001;
    tick(1);
    chk("s2_p", pressed, 5'b00001);
    tick(9);
    btn = '0;
    tick(1);
    chk("s2_r", released, 5'b00001);
    tick(20);
    chk("s2_h", held, 5'b0);
    clr_all();

    // Second press restarts the shared timer
    btn = 5'b00010;
    tick(5);
    btn = 5'b01010;
    tick(1);
    chk("s3_p", pressed, 5'b01010);
    tick(15);
    chk("s3_hpre", held, 5'b0);
    tick(1);
    chk("s3_h", held, 5'b01010);
    clr_all();

    // Change one clock before the hold event aborts it
    btn = 5'b00010;
    tick(16);
    btn = 5'b00011;
    tick(1);
    chk("ab_h", held, 5'b0);
    chk("ab_p", pressed, 5'b00001);
    chk("ab_r", released, 5'b01000);
    tick(15);
    chk("ab_hpre", held, 5'b0);
    tick(1);
    chk("ab_h2", held, 5'b00011);
    clr_all();

    // Set wins over clear; partial mask
    btn = 5'b00010;
    tick(1);
    chk("s4_r", released, 5'b00001);
    clr_all();
    btn  = 5'b00011;
    clr  = 1'b1;
    mask = 5'b00001;
    tick(1);
    clr  = 1'b0;
    mask = '0;
    chk("s4_setwin", pressed, 5'b00001);
    clr  = 1'b1;
    mask = 5'b00010;
    tick(1);
    clr  = 1'b0;
    mask = '0;
    chk("s4_mask", pressed, 5'b00001);

    // Reset mid-count with buttons still down
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("s5_p0", pressed, 5'b0);
    chk("s5_r0", released, 5'b0);
    chk("s5_h0", held, 5'b0);
    chk("s5_int0", {4'b0, irq}, 5'b0);
    tick(1);
    chk("s5_p", pressed, 5'b00011);
    tick(15);
    chk("s5_hpre", held, 5'b0);
    tick(1);
    chk("s5_h", held, 5'b00011);

    // Auto-repeat while held
    btn = '0;
    tick(1);
    clr_all();
    btn = 5'b00100;
    tick(17);
    chk("s6_h", held, 5'b00100);
    clr_all();
    tick(6);
    chk("s6_pre1", pressed, 5'b0);
    tick(1);
    chk("s6_rep1", pressed, REP);
    clr_all();
    tick(6);
    chk("s6_pre2", pressed, 5'b0);
    tick(1);
    chk("s6_rep2", pressed, REP);
    chk("s6_hkeep", held, 5'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
